// File: rtl/wb_mem_slave.sv
// -----------------------------------------------------------------------------
// wb_mem_slave
//   Wishbone pipelined responder in front of a 32-bit word memory. Accepted
//   requests go into a small in-order queue. Each head entry waits LATENCY
//   cycles, then executes, and is acknowledged in the following cycle.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, >= 16)
//   LATENCY      wait cycles inserted per request (0..15)
//   QUEUE_DEPTH  request queue entries (power of two, >= 2)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   wb_adr_i     byte address; word index = adr[log2(DEPTH_WORDS)+1:2]
//   wb_dat_i     write data
//   wb_dat_o     read data, valid with ack, zero otherwise
//   wb_sel_i     byte lane selects (writes only)
//   wb_we_i      write enable
//   wb_stb_i     strobe
//   wb_cyc_i     bus cycle; low flushes all queued work
//   wb_ack_o     one-cycle acknowledge per accepted request
//   wb_stall_o   high while the queue is full
//   wb_err_o     (only with WB_MEM_SLAVE_ERR_EN) out-of-range access response
//
// Build option
//   WB_MEM_SLAVE_ERR_EN  with this macro defined, addresses at or beyond
//                        DEPTH_WORDS*4 respond with wb_err_o, and storage is
//                        not written. With the macro undefined, such
//                        addresses wrap modulo DEPTH_WORDS.
// -----------------------------------------------------------------------------
module wb_mem_slave #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 0,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        wb_stall_o
`ifdef WB_MEM_SLAVE_ERR_EN
  ,output logic        wb_err_o
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
   localparam logic [3:0]       LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, EXEC} state_t;

   // State entered whenever a new entry becomes the queue head.
   localparam state_t ARRIVE = (LATENCY > 0) ? WAIT : EXEC;

   // Request queue storage
   logic [IDX_W-1:0] fifo_idx_q [QUEUE_DEPTH];
   logic [31:0]      fifo_dat_q [QUEUE_DEPTH];
   logic [3:0]       fifo_sel_q [QUEUE_DEPTH];
   logic             fifo_we_q  [QUEUE_DEPTH];
`ifdef WB_MEM_SLAVE_ERR_EN
   logic             fifo_oor_q [QUEUE_DEPTH];
`endif

   logic [31:0] mem [DEPTH_WORDS];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_t           state_q, state_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             err_q, err_d;

   logic             push;
   logic             pop;
   logic             mem_we;
   logic [IDX_W-1:0] head_idx;
   logic [31:0]      head_dat;
   logic [3:0]       head_sel;
   logic             head_we;
   logic             head_oor;

   // Stall comes straight from the registered occupancy. A pop in the same
   // cycle does not free the slot early.
   assign wb_stall_o = (count_q == FULL_CNT);
   assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;
   // The head is only executed while the cycle is still open.
   assign pop        = (state_q == EXEC) & wb_cyc_i;

   assign head_idx = fifo_idx_q[rd_ptr_q];
   assign head_dat = fifo_dat_q[rd_ptr_q];
   assign head_sel = fifo_sel_q[rd_ptr_q];
   assign head_we  = fifo_we_q[rd_ptr_q];

`ifdef WB_MEM_SLAVE_ERR_EN
   assign head_oor = fifo_oor_q[rd_ptr_q];
   logic unused_adr_bits;
   assign unused_adr_bits = ^wb_adr_i[1:0];
`else
   assign head_oor = 1'b0;
   // Byte offset and the bits above the word index are ignored, so the
   // address wraps modulo DEPTH_WORDS.
   logic unused_adr_bits;
   assign unused_adr_bits = ^{wb_adr_i[31:IDX_W+2], wb_adr_i[1:0]};
`endif

   // NOTE: every variable gets a default at the top of a combinational block,
   // so that no path leaves a variable unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = '0;
      mem_we    = 1'b0;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      unique case (state_q)
         IDLE: begin
            // The queue is empty in IDLE, so only a fresh push can start work.
            if (push) state_d = ARRIVE;
         end
         WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d   = EXEC;
               lat_cnt_d = 4'd0;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         EXEC: begin
            lat_cnt_d = 4'd0;
            // Entries still queued after this pop, plus any pushed now.
            if (count_q > CNT_W'(1) || push) state_d = ARRIVE;
            else                             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         ack_d  = ~head_oor;
         err_d  = head_oor;
         mem_we = head_we & ~head_oor;
         if (!head_we && !head_oor) dat_d = mem[head_idx];
      end

      // Dropping cyc abandons everything queued. Outputs are already
      // suppressed because pop requires cyc.
      if (!wb_cyc_i) begin
         state_d   = IDLE;
         lat_cnt_d = 4'd0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         lat_cnt_q <= 4'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_q     <= dat_d;
      end
   end

   // NOTE: queue payload and storage have no reset. Validity is tracked by the
   // pointers and count, and memory contents must survive reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_idx_q[wr_ptr_q] <= wb_adr_i[IDX_W+1:2];
         fifo_dat_q[wr_ptr_q] <= wb_dat_i;
         fifo_sel_q[wr_ptr_q] <= wb_sel_i;
         fifo_we_q[wr_ptr_q]  <= wb_we_i;
`ifdef WB_MEM_SLAVE_ERR_EN
         fifo_oor_q[wr_ptr_q] <= |wb_adr_i[31:IDX_W+2];
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (head_sel[b]) mem[head_idx][8*b +: 8] <= head_dat[8*b +: 8];
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;

`ifdef WB_MEM_SLAVE_ERR_EN
   assign wb_err_o = err_q;
`else
   // err_q is held at 0 when there is no error port.
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_slave
//   Three wb_mem_slave instances (LATENCY 0, 3, 2; DEPTH_WORDS 1024;
//   QUEUE_DEPTH 4) are driven one at a time. Expected responses are queued
//   when a request is issued. A monitor pops them as ack/err pulses appear.
//   Define WB_MEM_SLAVE_ERR_EN to build the error-response variant.
// -----------------------------------------------------------------------------
module tb_wb_mem_slave;

`ifdef WB_MEM_SLAVE_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      int          inst;
      logic [31:0] data;
      logic        is_err;
      int          exp_cyc;   // edge index of the response, -1 = any
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr  [3];
   logic [31:0] wdat [3];
   logic [31:0] rdat [3];
   logic [3:0]  sel  [3];
   logic        we   [3];
   logic        stb  [3];
   logic        cyc  [3];
   logic        ack  [3];
   logic        stall[3];
`ifdef WB_MEM_SLAVE_ERR_EN
   logic        err  [3];
`endif

   exp_t sb[$];
   int   ack_cyc[$];
   int   cycle  = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_mem_slave #(
         .DEPTH_WORDS (1024),
         .LATENCY     ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
         .QUEUE_DEPTH (4)
      ) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .wb_adr_i   (adr[g]),
         .wb_dat_i   (wdat[g]),
         .wb_dat_o   (rdat[g]),
         .wb_sel_i   (sel[g]),
         .wb_we_i    (we[g]),
         .wb_stb_i   (stb[g]),
         .wb_cyc_i   (cyc[g]),
         .wb_ack_o   (ack[g]),
         .wb_stall_o (stall[g])
`ifdef WB_MEM_SLAVE_ERR_EN
        ,.wb_err_o   (err[g])
`endif
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      logic got_ack;
      logic got_err;
      for (int i = 0; i < 3; i++) begin
         got_ack = ack[i];
`ifdef WB_MEM_SLAVE_ERR_EN
         got_err = err[i];
`else
         got_err = 1'b0;
`endif
         if (got_ack || got_err) begin
            if (sb.size() == 0) begin
               check("resp_without_request", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check("resp_inst", 32'(i), 32'(e.inst));
               check("resp_ack", 32'(got_ack), 32'(!e.is_err));
`ifdef WB_MEM_SLAVE_ERR_EN
               check("resp_err", 32'(got_err), 32'(e.is_err));
`endif
               check("resp_data", rdat[i], e.data);
               if (e.exp_cyc >= 0) check("resp_cycle", 32'(cycle), 32'(e.exp_cyc));
               ack_cyc.push_back(cycle);
            end
         end
      end
   end

   // Drive one request at a negedge and hold it until it is accepted.
   task automatic req(input int u, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w, input bit expect_resp,
                      input logic [31:0] exp_data, input logic exp_err,
                      input int exp_lat, output int waited);
      exp_t e;
      int   acc;
      @(negedge clk);
      cyc[u]  = 1'b1;
      stb[u]  = 1'b1;
      adr[u]  = a;
      wdat[u] = d;
      sel[u]  = s;
      we[u]   = w;
      waited  = 0;
      while (stall[u] && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 64) check("req_stall_timeout", 32'(stall[u]), 32'd0);
      acc = cycle + 1;
      if (expect_resp) begin
         e.inst    = u;
         e.data    = exp_data;
         e.is_err  = exp_err;
         e.exp_cyc = (exp_lat >= 0) ? acc + exp_lat : -1;
         sb.push_back(e);
      end
   endtask

   task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int lat);
      int w;
      req(u, a, d, s, 1'b1, 1'b1, 32'h0, 1'b0, lat, w);
   endtask

   task automatic rd(input int u, input logic [31:0] a, input logic [31:0] exp, input int lat);
      int w;
      req(u, a, 32'h0, 4'hF, 1'b0, 1'b1, exp, 1'b0, lat, w);
   endtask

   task automatic idle(input int u);
      @(negedge clk);
      stb[u] = 1'b0;
      we[u]  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int w [6];
      int w0;
      int n;
      int base;

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = '0; wdat[i] = '0; sel[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_ack",   32'(ack[i]),   32'd0);
         check("rst_stall", 32'(stall[i]), 32'd0);
         check("rst_dat",   rdat[i],       32'd0);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // LATENCY 0: write then read back-to-back
      wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
      rd(0, 32'h10, 32'hDEADBEEF, 1);
      idle(0);
      drain();
      check("b2b_ack_gap", 32'(ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2]), 32'd1);

      // Byte-lane writes, and the low address bits are ignored
      wr(0, 32'h20, 32'h11223344, 4'hF, 1);
      wr(0, 32'h20, 32'h000000AA, 4'h1, 1);
      rd(0, 32'h20, 32'h112233AA, 1);
      wr(0, 32'h20, 32'hA5A50000, 4'hC, 1);
      rd(0, 32'h23, 32'hA5A533AA, 1);
      idle(0);
      drain();

      // Out-of-range address: wraps to word 0 or responds with err
      wr(0, 32'h0, 32'h00000077, 4'hF, 1);
      req(0, 32'h1000, 32'h5, 4'hF, 1'b1, 1'b1, 32'h0, ERR_EN, 1, w0);
      rd(0, 32'h0, ERR_EN ? 32'h77 : 32'h5, 1);
      req(0, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b1, ERR_EN ? 32'h0 : 32'h5, ERR_EN, 1, w0);
      idle(0);
      drain();

      // LATENCY 3: fill six words, then six reads with stb held
      for (int i = 0; i < 6; i++) wr(1, 32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, -1);
      idle(1);
      drain();
      base = ack_cyc.size();
      for (int i = 0; i < 6; i++)
         req(1, 32'h100 + 32'(4*i), 32'h0, 4'hF, 1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b0,
             (i == 0) ? 4 : -1, w[i]);
      idle(1);
      drain();
      for (int i = 0; i < 6; i++)
         check("l3_stall_wait", 32'(w[i]), (i < 4) ? 32'd0 : ((i == 4) ? 32'd1 : 32'd3));
      for (int i = 1; i < 6; i++)
         check("l3_ack_gap", 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd4);

      // LATENCY 2: three writes queued, cyc dropped after the first ack
      wr(2, 32'h44, 32'h11111111, 4'hF, 3);
      idle(2);
      drain();
      req(2, 32'h40, 32'hC0C0C0C0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, 3, w0);
      req(2, 32'h44, 32'hBAD0BAD0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0, -1, w0);
      req(2, 32'h48, 32'hBAD1BAD1, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0, -1, w0);
      idle(2);
      n = 0;
      while (!ack[2] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("flush_first_ack", 32'(ack[2]), 32'd1);
      cyc[2] = 1'b0;
      @(negedge clk);
      check("flush_stall", 32'(stall[2]), 32'd0);
      check("flush_ack",   32'(ack[2]),   32'd0);
      repeat (8) @(negedge clk);
      rd(2, 32'h44, 32'h11111111, 3);
      idle(2);
      drain();
      rd(2, 32'h40, 32'hC0C0C0C0, 3);
      idle(2);
      drain();

      // Reset pulse with two requests queued
      req(1, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, -1, w0);
      req(1, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, -1, w0);
      @(negedge clk);
      stb[1] = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      check("midrst_ack",   32'(ack[1]),   32'd0);
      check("midrst_stall", 32'(stall[1]), 32'd0);
      check("midrst_dat",   rdat[1],       32'd0);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("postrst_ack", 32'(ack[1]), 32'd0);
      rd(1, 32'h100, 32'hA0000000, 4);
      rd(1, 32'h104, 32'hA0000001, -1);
      idle(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
